// File: rtl/hdmi_timing_scanout.sv
// Programmable HSYNC/VSYNC/DE timing generator with per-line frame-buffer fetch requests.
// Timing and base address are double-buffered and only change on frame boundaries.
module hdmi_timing_scanout #(
    parameter int unsigned C_CNT_BITS       = 12,
    parameter int unsigned C_ADDR_BITS      = 6,
    parameter logic [31:0] C_DEFAULT_BASE   = 32'h8000_0000,
    parameter logic [31:0] C_DEFAULT_STRIDE = 32'd7680,
    parameter int unsigned C_H_ACTIVE       = 1920,
    parameter int unsigned C_H_TOTAL        = 2200,
    parameter int unsigned C_HS_START       = 2008,
    parameter int unsigned C_HS_END         = 2052,
    parameter int unsigned C_V_ACTIVE       = 1080,
    parameter int unsigned C_V_TOTAL        = 1125,
    parameter int unsigned C_VS_START       = 1084,
    parameter int unsigned C_VS_END         = 1089
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WE,
    input  logic [C_ADDR_BITS-1:0] WADDR,
    input  logic [31:0]            WDATA,
    input  logic                   RE,
    input  logic [C_ADDR_BITS-1:0] RADDR,
    output logic [31:0]            RDATA,
    output logic                   HSYNC,
    output logic                   VSYNC,
    output logic                   DE,
    output logic [C_CNT_BITS-1:0]  PIX_X,
    output logic [C_CNT_BITS-1:0]  PIX_Y,
    output logic                   LINE_REQ,
    output logic [31:0]            LINE_ADDR,
    output logic [C_CNT_BITS-1:0]  LINE_Y,
    output logic                   IRQ
);

    typedef logic [C_CNT_BITS-1:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);

    typedef enum logic [C_ADDR_BITS-3:0] {
        REG_CTRL, REG_H0, REG_H1, REG_V0, REG_V1, REG_BASE, REG_STRIDE, REG_STATUS
    } reg_idx_e;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e state;
    logic [3:0]  ctrl;
    logic [31:0] base, stride, active_base;
    logic        pending;
    cnt_t        h, v;
    cnt_t h_active_p, h_total_p, hs_start_p, hs_end_p;
    cnt_t v_active_p, v_total_p, vs_start_p, vs_end_p;
    cnt_t h_active_s, h_total_s, hs_start_s, hs_end_s;
    cnt_t v_active_s, v_total_s, vs_start_s, vs_end_s;

    logic enable, hs_pol, vs_pol, irq_en;
    assign enable = ctrl[0];
    assign hs_pol = ctrl[1];
    assign vs_pol = ctrl[2];
    assign irq_en = ctrl[3];

    logic [C_ADDR_BITS-3:0] widx, ridx;
    assign widx = WADDR[C_ADDR_BITS-1:2];
    assign ridx = RADDR[C_ADDR_BITS-1:2];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{WADDR[1:0], RADDR[1:0]};

    logic we_base, irq_clr, active, h_last, v_last, req_hit, commit, frame_start, vblank;
    cnt_t next_line;

    always_comb begin
        we_base     = WE && (widx == REG_BASE);
        irq_clr     = WE && (widx == REG_STATUS) && WDATA[2];
        active      = (state == ST_RUN) && enable;
        h_last      = (h == h_total_s - ONE);
        v_last      = (v == v_total_s - ONE);
        next_line   = v_last ? '0 : v + ONE;
        req_hit     = active && (h == h_active_s) && (next_line < v_active_s);
        commit      = req_hit && (next_line == '0);
        frame_start = active && (h == '0) && (v == '0);
        vblank      = (v >= v_active_s);
    end

    // Program-side register file and registered read port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl       <= '0;
            base       <= C_DEFAULT_BASE;
            stride     <= C_DEFAULT_STRIDE;
            h_active_p <= cnt_t'(C_H_ACTIVE);
            h_total_p  <= cnt_t'(C_H_TOTAL);
            hs_start_p <= cnt_t'(C_HS_START);
            hs_end_p   <= cnt_t'(C_HS_END);
            v_active_p <= cnt_t'(C_V_ACTIVE);
            v_total_p  <= cnt_t'(C_V_TOTAL);
            vs_start_p <= cnt_t'(C_VS_START);
            vs_end_p   <= cnt_t'(C_VS_END);
        end else if (WE) begin
            case (widx)
                REG_CTRL:   ctrl <= WDATA[3:0];
                REG_H0: begin
                    h_total_p  <= WDATA[16 +: C_CNT_BITS];
                    h_active_p <= WDATA[0 +: C_CNT_BITS];
                end
                REG_H1: begin
                    hs_end_p   <= WDATA[16 +: C_CNT_BITS];
                    hs_start_p <= WDATA[0 +: C_CNT_BITS];
                end
                REG_V0: begin
                    v_total_p  <= WDATA[16 +: C_CNT_BITS];
                    v_active_p <= WDATA[0 +: C_CNT_BITS];
                end
                REG_V1: begin
                    vs_end_p   <= WDATA[16 +: C_CNT_BITS];
                    vs_start_p <= WDATA[0 +: C_CNT_BITS];
                end
                REG_BASE:   base   <= WDATA;
                REG_STRIDE: stride <= WDATA;
                default: ;
            endcase
        end
    end

    logic [31:0] rdata_next;

    always_comb begin
        rdata_next = '0;
        case (ridx)
            REG_CTRL:   rdata_next = {28'd0, ctrl};
            REG_H0:     rdata_next = {16'(h_total_p), 16'(h_active_p)};
            REG_H1:     rdata_next = {16'(hs_end_p), 16'(hs_start_p)};
            REG_V0:     rdata_next = {16'(v_total_p), 16'(v_active_p)};
            REG_V1:     rdata_next = {16'(vs_end_p), 16'(vs_start_p)};
            REG_BASE:   rdata_next = base;
            REG_STRIDE: rdata_next = stride;
            REG_STATUS: rdata_next = {16'(v), 13'd0, IRQ, vblank, pending};
            default:    rdata_next = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RDATA <= '0;
        end else if (RE) begin
            RDATA <= rdata_next;
        end
    end

    // Counter FSM, shadow timing, and all registered video/fetch outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            h           <= '0;
            v           <= '0;
            h_active_s  <= cnt_t'(C_H_ACTIVE);
            h_total_s   <= cnt_t'(C_H_TOTAL);
            hs_start_s  <= cnt_t'(C_HS_START);
            hs_end_s    <= cnt_t'(C_HS_END);
            v_active_s  <= cnt_t'(C_V_ACTIVE);
            v_total_s   <= cnt_t'(C_V_TOTAL);
            vs_start_s  <= cnt_t'(C_VS_START);
            vs_end_s    <= cnt_t'(C_VS_END);
            active_base <= C_DEFAULT_BASE;
            pending     <= 1'b0;
            IRQ         <= 1'b0;
            HSYNC       <= 1'b0;
            VSYNC       <= 1'b0;
            DE          <= 1'b0;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            LINE_REQ    <= 1'b0;
            LINE_ADDR   <= '0;
            LINE_Y      <= '0;
        end else begin
            if (!enable) begin
                state <= ST_IDLE;
                h     <= '0;
                v     <= '0;
            end else if (state == ST_IDLE) begin
                // Start on the last line so the line-0 fetch precedes frame 0.
                state      <= ST_RUN;
                h          <= '0;
                v          <= v_total_p - ONE;
                h_active_s <= h_active_p;
                h_total_s  <= h_total_p;
                hs_start_s <= hs_start_p;
                hs_end_s   <= hs_end_p;
                v_active_s <= v_active_p;
                v_total_s  <= v_total_p;
                vs_start_s <= vs_start_p;
                vs_end_s   <= vs_end_p;
            end else if (h_last) begin
                h <= '0;
                if (v_last) begin
                    v          <= '0;
                    h_active_s <= h_active_p;
                    h_total_s  <= h_total_p;
                    hs_start_s <= hs_start_p;
                    hs_end_s   <= hs_end_p;
                    v_active_s <= v_active_p;
                    v_total_s  <= v_total_p;
                    vs_start_s <= vs_start_p;
                    vs_end_s   <= vs_end_p;
                end else begin
                    v <= v + ONE;
                end
            end else begin
                h <= h + ONE;
            end

            DE    <= active && (h < h_active_s) && (v < v_active_s);
            HSYNC <= (active && (h >= hs_start_s) && (h < hs_end_s)) ^ hs_pol;
            VSYNC <= (active && (v >= vs_start_s) && (v < vs_end_s)) ^ vs_pol;
            PIX_X <= h;
            PIX_Y <= v;

            LINE_REQ <= req_hit;
            if (req_hit) begin
                LINE_Y <= next_line;
                if (commit) begin
                    LINE_ADDR <= pending ? base : active_base;
                end else begin
                    LINE_ADDR <= LINE_ADDR + stride;
                end
            end
            if (commit && pending) begin
                active_base <= base;
            end

            // A BASE write coinciding with commit stays pending for the next frame.
            if (we_base) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end

            if (frame_start && irq_en) begin
                IRQ <= 1'b1;
            end else if (irq_clr) begin
                IRQ <= 1'b0;
            end
        end
    end

endmodule
